// File: rtl/yuv_pkg.sv
// Shared definitions for the YUV camera capture path: FSM state encoding and
// default line/byte geometry (also used to size the downstream frame RAM).
package yuv_pkg;

    localparam int LINE_PIX   = 1280;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        ACTIVE    = 2'd2,
        SKIP      = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head is valid whenever not empty.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/yuyv_420_pack.sv
// Converts a YUYV 4:2:2 camera stream to 4:2:0 by keeping full YUYV on even
// lines and only luma on odd lines, buffering the result for the frame RAM.
module yuyv_420_pack #(
    parameter int LINE_PIX   = yuv_pkg::LINE_PIX,
    parameter int DATA_WIDTH = yuv_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [DATA_WIDTH-1:0] cam_data,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  ovf_o,
    output logic                  line_err
);

    import yuv_pkg::*;

    localparam int             BW         = $clog2(2 * LINE_PIX) + 1;
    localparam logic [BW-1:0]  LINE_BYTES = BW'(2 * LINE_PIX);

    state_t        state;
    state_t        next_state;
    logic          href_q;
    logic          vsync_q;
    logic [BW-1:0] b;
    logic          parity;
    logic          err_seen;
    logic          ovf_q;
    logic          line_err_q;

    logic          href_rise;
    logic          href_fall;
    logic          vsync_rise;
    logic          sample;
    logic          push_req;
    logic          excess;
    logic          overflow;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign href_rise  =  cam_href  && !href_q;
    assign href_fall  = !cam_href  &&  href_q;
    assign vsync_rise =  cam_vsync && !vsync_q;

    assign w_valid   = !fifo_empty;
    assign fifo_pop  = w_valid && w_ready;
    assign fifo_push = push_req && !overflow;
    assign ovf_o     = ovf_q;
    assign line_err  = line_err_q;

    // The first byte of a line arrives in the same cycle as the href rise, so
    // WAIT_LINE already samples it. A vsync rise cycle never samples.
    always_comb begin
        sample     = 1'b0;
        push_req   = 1'b0;
        excess     = 1'b0;
        overflow   = 1'b0;
        next_state = state;

        if (!vsync_rise && cam_href &&
            (state == ACTIVE || (state == WAIT_LINE && href_rise))) begin
            sample = 1'b1;
        end

        if (sample) begin
            if (b < LINE_BYTES) push_req = !parity || !b[0];
            else                excess   = 1'b1;
        end

        overflow = push_req && fifo_full && !fifo_pop;

        case (state)
            IDLE:      next_state = IDLE;
            WAIT_LINE: if (href_rise) next_state = ACTIVE;
            ACTIVE:    if (href_fall) next_state = WAIT_LINE;
            SKIP:      next_state = SKIP;
            default:   next_state = IDLE;
        endcase

        if (overflow && state != SKIP) next_state = SKIP;
        if (vsync_rise)                next_state = WAIT_LINE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Line bookkeeping: byte index, line parity, sticky overflow and the
    // once-per-line length error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            b          <= '0;
            parity     <= 1'b0;
            err_seen   <= 1'b0;
            ovf_q      <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            href_q     <= cam_href;
            vsync_q    <= cam_vsync;
            line_err_q <= 1'b0;
            if (vsync_rise) begin
                b        <= '0;
                parity   <= 1'b0;
                err_seen <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                if (overflow) ovf_q <= 1'b1;
                if (href_fall) begin
                    b        <= '0;
                    parity   <= ~parity;
                    err_seen <= 1'b0;
                    if (state == ACTIVE && b != LINE_BYTES && !err_seen) line_err_q <= 1'b1;
                end else begin
                    if (sample && !excess) b <= b + 1'b1;
                    if (excess && !err_seen) begin
                        line_err_q <= 1'b1;
                        err_seen   <= 1'b1;
                    end
                end
            end
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(cam_data),
        .pop      (fifo_pop),
        .head     (data_in),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_yuyv_420_pack.sv
// Directed bench for yuyv_420_pack with LINE_PIX=4 and FIFO_DEPTH=16.
module tb_yuyv_420_pack;

    import yuv_pkg::*;

    localparam int LP = 4;
    localparam int DW = 8;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cam_vsync;
    logic          cam_href;
    logic [DW-1:0] cam_data;
    logic [DW-1:0] data_in;
    logic          w_valid;
    logic          w_ready;
    logic          ovf_o;
    logic          line_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] out_q[$];
    int            err_cycles = 0;
    int            stall_viol = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    yuyv_420_pack #(.LINE_PIX(LP), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .data_in(data_in), .w_valid(w_valid), .w_ready(w_ready),
        .ovf_o(ovf_o), .line_err(line_err)
    );

    always #5 clk = ~clk;

    // Output monitor: records accepted bytes, line_err cycles and stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_valid && w_ready) out_q.push_back(data_in);
            if (line_err) err_cycles <= err_cycles + 1;
            if (stall_prev && (!w_valid || data_in !== stall_data)) stall_viol <= stall_viol + 1;
            stall_prev <= w_valid && !w_ready;
            stall_data <= data_in;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        tick(); cam_vsync = 1'b1;
        tick(); tick(); cam_vsync = 1'b0;
        tick(); tick();
    endtask

    task automatic send_line(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            tick(); cam_href = 1'b1; cam_data = base + 8'(i);
        end
        tick(); cam_href = 1'b0; cam_data = '0;
        repeat (3) tick();
    endtask

    task automatic wait_drain(output bit timed_out);
        int idle = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!w_valid) idle++; else idle = 0;
            if (idle >= 4) begin
                timed_out = 1'b0;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        int s;
        rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0; w_ready = 1'b1;
        #3;
        checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_valid got %b expected 0", w_valid); end
        checks++; if (data_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_in got %h expected 00", data_in); end
        checks++; if (ovf_o !== 1'b0 || line_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got ovf=%b lerr=%b expected 0 0", ovf_o, line_err); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d expected IDLE", dut.state); end
        tick(); tick(); rst_n = 1'b1; tick();
        s = out_q.size();
        send_line(8'hE0, 8);
        repeat (4) tick();
        checks++; if (out_q.size() !== s) begin errors++; $display("[TB] FAIL no_push_before_vsync got %0d bytes expected 0", out_q.size() - s); end
    endtask

    task automatic test_nominal();
        int s, e0;
        bit to;
        logic [7:0] expv[$];
        logic [7:0] got;
        for (int i = 0; i < 8; i++) expv.push_back(8'(i));
        for (int i = 0; i < 4; i++) expv.push_back(8'h10 + 8'(2 * i));
        w_ready = 1'b1;
        vsync_pulse();
        s = out_q.size(); e0 = err_cycles;
        tick(); cam_href = 1'b1; cam_data = 8'h00;
        @(negedge clk);
        checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_before_push got w_valid=%b expected 0", w_valid); end
        for (int i = 1; i < 8; i++) begin
            tick(); cam_data = 8'(i);
            if (i == 1) begin
                @(negedge clk);
                checks++;
                if (w_valid !== 1'b1 || data_in !== 8'h00) begin
                    errors++; $display("[TB] FAIL latency_one_cycle got v=%b d=%h expected v=1 d=00", w_valid, data_in);
                end
            end
        end
        tick(); cam_href = 1'b0; cam_data = '0;
        repeat (3) tick();
        send_line(8'h10, 8);
        wait_drain(to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL nominal_drain_timeout got timeout expected drain"); end
        checks++; if (out_q.size() - s !== 12) begin errors++; $display("[TB] FAIL nominal_count got %0d expected 12", out_q.size() - s); end
        for (int i = 0; i < expv.size(); i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 8'hxx;
            checks++; if (got !== expv[i]) begin errors++; $display("[TB] FAIL nominal_byte[%0d] got %h expected %h", i, got, expv[i]); end
        end
        checks++; if (err_cycles - e0 !== 0) begin errors++; $display("[TB] FAIL nominal_line_err got %0d expected 0", err_cycles - e0); end
    endtask

    task automatic test_backpressure();
        int s, v0;
        bit to, done;
        logic [7:0] expv[$];
        logic [7:0] got;
        for (int i = 0; i < 8; i++) expv.push_back(8'(i));
        for (int i = 0; i < 4; i++) expv.push_back(8'h10 + 8'(2 * i));
        s = out_q.size(); v0 = stall_viol; done = 1'b0;
        fork
            begin
                vsync_pulse(); send_line(8'h00, 8); send_line(8'h10, 8);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick(); w_ready = ~w_ready;
                end
            end
        join
        w_ready = 1'b1;
        wait_drain(to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_timeout got timeout expected drain"); end
        checks++; if (out_q.size() - s !== 12) begin errors++; $display("[TB] FAIL bp_count got %0d expected 12", out_q.size() - s); end
        for (int i = 0; i < expv.size(); i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 8'hxx;
            checks++; if (got !== expv[i]) begin errors++; $display("[TB] FAIL bp_byte[%0d] got %h expected %h", i, got, expv[i]); end
        end
        checks++; if (stall_viol - v0 !== 0) begin errors++; $display("[TB] FAIL bp_stall_stable got %0d violations expected 0", stall_viol - v0); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_ovf got %b expected 0", ovf_o); end
    endtask

    task automatic test_overflow();
        int s;
        bit to;
        logic [7:0] got;
        w_ready = 1'b0;
        vsync_pulse();
        s = out_q.size();
        send_line(8'h00, 8);
        send_line(8'h10, 8);
        for (int i = 0; i < 8; i++) begin
            tick(); cam_href = 1'b1; cam_data = 8'h20 + 8'(i);
            if (i == 4) begin
                checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_at_16 got %b expected 0", ovf_o); end
            end
            if (i == 5) begin
                checks++; if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_at_17 got %b expected 1", ovf_o); end
                checks++; if (dut.state !== SKIP) begin errors++; $display("[TB] FAIL ovf_state got %0d expected SKIP", dut.state); end
            end
        end
        tick(); cam_href = 1'b0; cam_data = '0;
        repeat (3) tick();
        send_line(8'h30, 8);
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b expected 1", ovf_o); end
        w_ready = 1'b1;
        wait_drain(to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain_timeout got timeout expected drain"); end
        checks++; if (out_q.size() - s !== 16) begin errors++; $display("[TB] FAIL ovf_drain_count got %0d expected 16", out_q.size() - s); end
        got = (s + 15 < out_q.size()) ? out_q[s + 15] : 8'hxx;
        checks++; if (got !== 8'h23) begin errors++; $display("[TB] FAIL ovf_last_byte got %h expected 23", got); end
        vsync_pulse();
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b expected 0", ovf_o); end
        s = out_q.size();
        send_line(8'h40, 8);
        wait_drain(to);
        checks++; if (out_q.size() - s !== 8) begin errors++; $display("[TB] FAIL ovf_resume_count got %0d expected 8", out_q.size() - s); end
        for (int i = 0; i < 8; i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 8'hxx;
            checks++; if (got !== 8'h40 + 8'(i)) begin errors++; $display("[TB] FAIL ovf_resume_byte[%0d] got %h expected %h", i, got, 8'h40 + 8'(i)); end
        end
    endtask

    task automatic test_line_length();
        int s, e0;
        bit to;
        logic [7:0] expv[$];
        logic [7:0] got;
        for (int i = 0; i < 6; i++) expv.push_back(8'h50 + 8'(i));
        for (int i = 0; i < 4; i++) expv.push_back(8'h60 + 8'(2 * i));
        for (int i = 0; i < 8; i++) expv.push_back(8'h70 + 8'(i));
        w_ready = 1'b1;
        vsync_pulse();
        s = out_q.size(); e0 = err_cycles;
        send_line(8'h50, 6);
        checks++; if (err_cycles - e0 !== 1) begin errors++; $display("[TB] FAIL short_line_err got %0d expected 1", err_cycles - e0); end
        send_line(8'h60, 8);
        send_line(8'h70, 10);
        wait_drain(to);
        checks++; if (err_cycles - e0 !== 2) begin errors++; $display("[TB] FAIL long_line_err got %0d expected 2", err_cycles - e0); end
        checks++; if (out_q.size() - s !== 18) begin errors++; $display("[TB] FAIL len_count got %0d expected 18", out_q.size() - s); end
        for (int i = 0; i < expv.size(); i++) begin
            got = (s + i < out_q.size()) ? out_q[s + i] : 8'hxx;
            checks++; if (got !== expv[i]) begin errors++; $display("[TB] FAIL len_byte[%0d] got %h expected %h", i, got, expv[i]); end
        end
    endtask

    task automatic test_mid_frame_vsync();
        int s, e0;
        bit to;
        logic [7:0] got;
        w_ready = 1'b1;
        vsync_pulse();
        s = out_q.size(); e0 = err_cycles;
        send_line(8'h80, 8);
        vsync_pulse();
        send_line(8'h90, 8);
        wait_drain(to);
        checks++; if (out_q.size() - s !== 16) begin errors++; $display("[TB] FAIL midv_count got %0d expected 16", out_q.size() - s); end
        for (int i = 0; i < 8; i++) begin
            got = (s + 8 + i < out_q.size()) ? out_q[s + 8 + i] : 8'hxx;
            checks++; if (got !== 8'h90 + 8'(i)) begin errors++; $display("[TB] FAIL midv_byte[%0d] got %h expected %h", i, got, 8'h90 + 8'(i)); end
        end
        checks++; if (err_cycles - e0 !== 0) begin errors++; $display("[TB] FAIL midv_line_err got %0d expected 0", err_cycles - e0); end
    endtask

    task automatic test_reset_mid_drain();
        int s;
        bit to;
        logic [7:0] got;
        w_ready = 1'b0;
        vsync_pulse();
        send_line(8'hA0, 5);
        @(negedge clk);
        checks++; if (w_valid !== 1'b1 || data_in !== 8'hA0) begin errors++; $display("[TB] FAIL rst_pre_queue got v=%b d=%h expected v=1 d=a0", w_valid, data_in); end
        tick(); w_ready = 1'b1;
        tick(); rst_n = 1'b0;
        #1;
        checks++; if (w_valid !== 1'b0 || data_in !== 8'h00) begin errors++; $display("[TB] FAIL rst_async got v=%b d=%h expected v=0 d=00", w_valid, data_in); end
        tick(); rst_n = 1'b1;
        s = out_q.size();
        repeat (6) tick();
        send_line(8'hB0, 8);
        repeat (4) tick();
        checks++; if (out_q.size() !== s) begin errors++; $display("[TB] FAIL rst_no_output got %0d bytes expected 0", out_q.size() - s); end
        vsync_pulse();
        send_line(8'hC0, 8);
        wait_drain(to);
        checks++; if (out_q.size() - s !== 8) begin errors++; $display("[TB] FAIL rst_resume_count got %0d expected 8", out_q.size() - s); end
        got = (s < out_q.size()) ? out_q[s] : 8'hxx;
        checks++; if (got !== 8'hC0) begin errors++; $display("[TB] FAIL rst_resume_first got %h expected c0", got); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_overflow();
        test_line_length();
        test_mid_frame_vsync();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/yuyv_420_pack.md
YUYV_420_PACK -- requirements
Module: yuyv_420_pack

Interface
REQ-001 Parameter LINE_PIX, default 1280, meaning Y pixels per camera line.
REQ-002 Parameter DATA_WIDTH, default 8, meaning byte width of the pixel and output data.
REQ-003 Parameter FIFO_DEPTH, default 16, meaning output FIFO entries; SHALL be a power of 2.
REQ-004 Port clk, input, 1, single clock; one clock, all logic on posedge.
REQ-005 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 Port cam_vsync, input, 1, frame sync; a rising edge starts a new frame.
REQ-007 Port cam_href, input, 1, line active; bytes are only sampled while high.
REQ-008 Port cam_data, input, DATA_WIDTH, YUYV byte (Y0 U0 Y1 V0 ...), sampled when cam_href=1.
REQ-009 Port data_in, output, DATA_WIDTH, byte to the frame RAM.
REQ-010 Port w_valid, output, 1, data_in valid.
REQ-011 Port w_ready, input, 1, frame RAM accepts the byte.
REQ-012 Port ovf_o, output, 1, sticky FIFO overflow for the current frame.
REQ-013 Port line_err, output, 1, one-cycle pulse on a line of wrong length.

Function
REQ-014 Byte index b within a line SHALL count 0..2*LINE_PIX-1 on sampled bytes; even b is Y, odd b is chroma.
REQ-015 Line parity SHALL be 0 for the first line after cam_vsync rise and SHALL toggle on each cam_href falling edge.
REQ-016 On parity-0 lines, every sampled byte with b<2*LINE_PIX SHALL be pushed to the FIFO (YUYV pass-through).
REQ-017 On parity-1 lines, only bytes with even b and b<2*LINE_PIX SHALL be pushed (Y only; chroma dropped, 4:2:0).
REQ-018 Each line-pair SHALL therefore yield exactly 3*LINE_PIX output bytes, in input order.
REQ-019 FSM states SHALL be IDLE, WAIT_LINE, ACTIVE and SKIP.
REQ-020 IDLE -> WAIT_LINE on the cam_vsync rising edge.
REQ-021 WAIT_LINE -> ACTIVE on the cam_href rising edge.
REQ-022 ACTIVE -> WAIT_LINE on the cam_href falling edge.
REQ-023 Any state except SKIP -> SKIP on overflow.
REQ-024 Any state -> WAIT_LINE on a cam_vsync rising edge.
REQ-025 A cam_vsync rising edge SHALL clear b, parity and ovf_o; it SHALL NOT flush the FIFO.
REQ-026 An href fall with b != 2*LINE_PIX, or any byte sampled with b >= 2*LINE_PIX, SHALL pulse line_err once per line; excess bytes are dropped and b clears at the href fall.
REQ-027 cam_href edges SHALL be detected against a 1-cycle registered copy; cam_vsync likewise.
REQ-028 The FIFO SHALL be first-word-fall-through.
REQ-029 w_valid SHALL equal FIFO not-empty, and data_in SHALL equal the FIFO head.
REQ-030 A pop SHALL occur when w_valid && w_ready.
REQ-031 Push-to-w_valid latency SHALL be 1 cycle when the FIFO is empty.
REQ-032 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; occupancy is then unchanged.
REQ-033 A push to a full FIFO without a simultaneous pop SHALL drop the byte, set ovf_o, and enter SKIP.
REQ-034 In SKIP no pushes SHALL occur until the next cam_vsync rise; the FIFO SHALL continue draining.
REQ-035 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping naturally; full is MSB-differ/rest-equal; empty is equal.
REQ-036 data_in and w_valid SHALL hold stable while w_valid && !w_ready.

Reset
REQ-037 During rst_n=0: state=IDLE; b, parity and FIFO pointers = 0; w_valid=0; data_in=0; ovf_o=0; line_err=0.
REQ-038 Reset mid-line or mid-drain SHALL discard FIFO contents.
REQ-039 After reset, no byte SHALL be pushed before the first cam_vsync rising edge.

Structure
REQ-040 Shared package yuv_pkg SHALL hold the FSM state enum, LINE_PIX, and DATA_WIDTH, also used by yuv_ram sizing.
REQ-041 The FIFO SHALL be one sub-module, sync_fifo_fwft (parameters DATA_WIDTH and FIFO_DEPTH, with push/pop/full/empty).
REQ-042 No other hierarchy SHALL be used.

Verification (LINE_PIX=4, FIFO_DEPTH=16)
REQ-043 Nominal: vsync rise, two lines of 8 bytes 0x00..0x07 and 0x10..0x17, w_ready=1 -> output 00..07 then 10,12,14,16; 12 bytes; line_err=0.
REQ-044 Backpressure: same stimulus with w_ready toggling 1-0-1-0 -> identical byte sequence; data_in stable while stalled; no ovf_o.
REQ-045 Overflow: w_ready=0 for 4 lines -> ovf_o=1 at the 17th push and state=SKIP; after w_ready=1 exactly 16 bytes drain; the next vsync clears ovf_o and resumes at parity 0.
REQ-046 Short/long line: href low after 6 bytes -> line_err pulse, next line parity 1; 10-byte line -> line_err, only 8 bytes pushed.
REQ-047 Mid-frame vsync: vsync rise after line 1 of 3 -> parity resets to 0, next line passes all 8 bytes.
REQ-048 Async reset asserted mid-drain with 5 bytes queued -> w_valid=0 immediately; no output until vsync and href.
